trace_cmd_issuer: RTL and testbench

- Producer end of the command/address/eof interface consumed by cache_statistics.
- Accepts decoded trace records from the trace-file reader through a valid/ready push port and buffers them in a small FIFO.
- Replays them onto the cache command bus, one command per issue slot. An idle gap separates commands so back-to-back identical commands each produce a bus change.
- Pulses eof after the last record of a trace has been issued.

---
 rtl/trace_cmd_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_trace_cmd_issuer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_issuer.sv
// trace_cmd_issuer
//   Producer end of the command/address/eof interface consumed by
//   cache_statistics. Trace records arrive on a valid/ready push port and are
//   buffered in a small FIFO. They are then replayed onto the cache command
//   bus one per issue slot, with an idle gap after every command. eof pulses
//   once after the last record of a trace has been issued.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  push handshake, record taken when both high at posedge
//   in_cmd/addr     trace command code and address
//   in_last         record is the final line of its trace
//   command/address registered command bus (IDLE_CMD when idle)
//   eof             one-cycle end-of-trace pulse
//   busy            FSM active or FIFO non-empty
//   issued_count    legal commands issued since reset (wrapping)
//   drop_count      illegal records discarded (saturating)
module trace_cmd_issuer #(
    parameter int                CMD_W       = 4,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 8,
    parameter int                HOLD_CYCLES = 1,
    parameter logic [CMD_W-1:0]  IDLE_CMD    = {CMD_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic [CMD_W-1:0]  command,
    output logic [ADDR_W-1:0] address,
    output logic              eof,
    output logic              busy,
    output logic [31:0]       issued_count,
    output logic [15:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_EOF} state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    // Legal trace codes are 0-6, 8 and 9; everything else is discarded.
    function automatic logic is_legal(input logic [CMD_W-1:0] c);
        return (c <= CMD_W'(6)) || (c == CMD_W'(8)) || (c == CMD_W'(9));
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               last_pending_q, last_pending_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               cur_last_q, cur_last_d;
    logic [CMD_W-1:0]   cur_cmd_q, cur_cmd_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [CMD_W-1:0]   command_q, command_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic               eof_q, eof_d;
    logic [31:0]        issued_q, issued_d;
    logic [15:0]        drop_q, drop_d;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic               full, empty, push, pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    // Blocking on last_pending keeps the next trace out until eof has gone.
    assign in_ready = !full && !last_pending_q;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        cur_last_d     = cur_last_q;
        cur_cmd_d      = cur_cmd_q;
        cur_addr_d     = cur_addr_q;
        last_pending_d = last_pending_q;
        command_d      = IDLE_CMD;
        address_d      = address_q;
        eof_d          = 1'b0;
        issued_d       = issued_q;
        drop_d         = drop_q;
        pop            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_legal(cur_cmd_q)) begin
                    command_d = cur_cmd_q;
                    address_d = cur_addr_q;
                    if (hold_q == '0) begin
                        issued_d = issued_q + 32'd1;
                    end
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    // Illegal entry: one silent slot, bus stays idle.
                    drop_d  = sat_inc16(drop_q);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cur_last_q) begin
                    state_d = S_EOF;
                end else if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EOF: begin
                eof_d          = 1'b1;
                last_pending_d = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            cur_cmd_d  = head.cmd;
            cur_addr_d = head.addr;
            cur_last_d = head.last;
        end

        if (push && in_last) begin
            last_pending_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_pending_q <= 1'b0;
            hold_q         <= '0;
            cur_last_q     <= 1'b0;
            command_q      <= IDLE_CMD;
            address_q      <= '0;
            eof_q          <= 1'b0;
            issued_q       <= '0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_pending_q <= last_pending_d;
            hold_q         <= hold_d;
            cur_last_q     <= cur_last_d;
            command_q      <= command_d;
            address_q      <= address_d;
            eof_q          <= eof_d;
            issued_q       <= issued_d;
            drop_q         <= drop_d;
        end
    end

    // Payload storage carries no reset; it is only read after a valid push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{cmd: in_cmd, addr: in_addr, last: in_last};
        end
        cur_cmd_q  <= cur_cmd_d;
        cur_addr_q <= cur_addr_d;
    end

    assign command      = command_q;
    assign address      = address_q;
    assign eof          = eof_q;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign issued_count = issued_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_trace_cmd_issuer.sv
// Directed bench for trace_cmd_issuer: reset values, single-record timing,
// repeated commands, backpressure, illegal codes and mid-trace reset.
module tb_trace_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_addr = '0;
    logic        in_last = 1'b0;
    logic [3:0]  command;
    logic [31:0] address;
    logic        eof;
    logic        busy;
    logic [31:0] issued_count;
    logic [15:0] drop_count;

    trace_cmd_issuer #(
        .CMD_W(4), .ADDR_W(32), .DEPTH(8), .HOLD_CYCLES(1), .IDLE_CMD(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_addr(in_addr), .in_last(in_last),
        .command(command), .address(address), .eof(eof), .busy(busy),
        .issued_count(issued_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
    } rec_t;

    int   total = 0;
    int   bad = 0;
    int   eof_cnt = 0;
    int   stall_cnt = 0;
    rec_t log_q [$];
    rec_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic legal(input logic [3:0] c);
        return (c inside {[4'd0:4'd6], 4'd8, 4'd9});
    endfunction

    // Bus monitor: every non-idle cycle is one issued command (HOLD_CYCLES=1).
    always @(negedge clk) begin
        if (rst_n) begin
            if (command != 4'hF) log_q.push_back('{c: command, a: address});
            if (eof) eof_cnt++;
        end
    end

    // Called at a negedge; leaves in_valid high after the accepting edge.
    task automatic push(input logic [3:0] c, input logic [31:0] a, input logic l);
        int g = 0;
        in_cmd   = c;
        in_addr  = a;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
            stall_cnt++;
        end
        if (!in_ready) begin
            chk("push_timeout", 0, 1);
        end else if (legal(c)) begin
            exp_q.push_back('{c: c, a: a});
        end
        @(negedge clk);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_ncmd"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_cmd"}, {28'd0, log_q[i].c, log_q[i].a}, {28'd0, exp_q[i].c, exp_q[i].a});
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_trace(input string tag, input int base);
        int g = 0;
        int leak = 0;
        while (!eof && g < 300) begin
            if (in_ready) leak++;
            @(negedge clk);
            g++;
        end
        chk({tag, "_eof"}, eof, 1);
        chk({tag, "_rdy_blocked"}, leak, 0);
        chk({tag, "_rdy_at_eof"}, in_ready, 1);
        chk({tag, "_eof_cmd_idle"}, command, 4'hF);
        @(negedge clk);
        chk({tag, "_eof_one_cycle"}, eof, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_eof_count"}, eof_cnt - base, 1);
        compare_logs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int base;

        // ---- asynchronous reset, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_command", command, 4'hF);
        chk("rst_address", address, 0);
        chk("rst_eof", eof, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_issued", issued_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- single record: cycle-exact timing
        in_cmd = 4'd0; in_addr = 32'h0000_1000; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("one_rdy_after_last", in_ready, 0);
        chk("one_cmd_n0", command, 4'hF);
        @(negedge clk);
        chk("one_cmd_n1", command, 4'hF);
        chk("one_busy", busy, 1);
        @(negedge clk);
        chk("one_cmd_n2", command, 4'd0);
        chk("one_addr_n2", address, 32'h1000);
        chk("one_issued", issued_count, 1);
        @(negedge clk);
        chk("one_cmd_n3", command, 4'hF);
        chk("one_addr_hold", address, 32'h1000);
        chk("one_eof_n3", eof, 0);
        chk("one_rdy_n3", in_ready, 0);
        @(negedge clk);
        chk("one_eof_n4", eof, 1);
        chk("one_rdy_n4", in_ready, 1);
        @(negedge clk);
        chk("one_eof_n5", eof, 0);
        chk("one_busy_end", busy, 0);
        log_q.delete();

        // ---- repeated identical commands
        base = eof_cnt;
        push(4'd1, 32'hA5A5_0040, 1'b0);
        push(4'd1, 32'hA5A5_0040, 1'b0);
        push(4'd1, 32'hA5A5_0040, 1'b1);
        in_valid = 1'b0;
        finish_trace("rep", base);
        chk("rep_issued", issued_count, 4);

        // ---- backpressure: 20 back-to-back records overrun the 8-deep FIFO
        base = eof_cnt;
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            push(4'(i % 7), 32'h0000_2000 + 32'(i * 4), (i == 19));
        end
        in_valid = 1'b0;
        chk("bp_stalled", (stall_cnt > 0), 1);
        finish_trace("bp", base);
        chk("bp_issued", issued_count, 24);

        // ---- illegal code followed by legal last record
        base = eof_cnt;
        push(4'd7, 32'h0000_0070, 1'b0);
        push(4'd9, 32'h0000_0090, 1'b1);
        in_valid = 1'b0;
        finish_trace("ill", base);
        chk("ill_drop", drop_count, 1);
        chk("ill_issued", issued_count, 25);

        // ---- trace ending in an illegal last record
        base = eof_cnt;
        push(4'd2, 32'h0000_0200, 1'b0);
        push(4'd12, 32'h0000_0C00, 1'b1);
        in_valid = 1'b0;
        finish_trace("ill_last", base);
        chk("ill_last_drop", drop_count, 2);
        chk("ill_last_issued", issued_count, 26);

        // ---- mid-trace reset with records queued
        for (int i = 0; i < 5; i++) begin
            push(4'd3, 32'h0000_3000 + 32'(i), (i == 4));
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_command", command, 4'hF);
        chk("mid_rst_address", address, 0);
        chk("mid_rst_eof", eof, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_issued", issued_count, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        exp_q.delete();
        base = eof_cnt;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_eof", eof_cnt - base, 0);
        chk("mid_rst_no_cmds", log_q.size(), 0);
        chk("mid_rst_idle", busy, 0);

        // ---- fresh trace after reset
        base = eof_cnt;
        push(4'd5, 32'h0000_5555, 1'b1);
        in_valid = 1'b0;
        finish_trace("post_rst", base);
        chk("post_rst_issued", issued_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
